// File: rtl/seq_alu.sv
// seq_alu: valid/ready execute-stage ALU. Base ops finish in one cycle; the
// RV32M-style multiply/divide ops iterate one bit per cycle (radix 2).
module seq_alu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int EN_M  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ALUCtrl,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  imm_rs2_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [SH_W-1:0] LAST_IT = SH_W'(XLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [SH_W-1:0]   cnt_r;
  logic              accept_s, start_m_s;
  logic [SH_W-1:0]   shamt_s;
  logic [XLEN-1:0]   base_res_s, fix_res_s;
  logic              sa_s, sb_s, neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic [2:0]        mop_r;
  logic              neg_r, b_zero_r;
  logic [TAG_W-1:0]  tag_r;
  logic [XLEN-1:0]   hi_r, lo_r, b_mag_r;
  logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;
  logic              out_valid_r;
  logic [XLEN-1:0]   alu_data_r;
  logic [TAG_W-1:0]  out_tag_r;

  assign busy      = (state_r != ST_IDLE);
  assign in_ready  = !busy && (!out_valid_r || out_ready) && !flush;
  assign accept_s  = in_valid && in_ready;
  assign start_m_s = accept_s && (EN_M != 0) && (ALUCtrl[4:3] == 2'b10);
  assign shamt_s   = imm_rs2_data[SH_W-1:0];

  // Single-cycle base operations; unlisted codes (and M codes when disabled) give 0
  always_comb begin
    base_res_s = {XLEN{1'b0}};
    case (ALUCtrl)
      5'b00000: base_res_s = rs1_data + imm_rs2_data;
      5'b01000: base_res_s = rs1_data - imm_rs2_data;
      5'b00001: base_res_s = rs1_data << shamt_s;
      5'b00101: base_res_s = rs1_data >> shamt_s;
      5'b01101: base_res_s = $unsigned($signed(rs1_data) >>> shamt_s);
      5'b00010: base_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(imm_rs2_data))};
      5'b00011: base_res_s = {{(XLEN-1){1'b0}}, (rs1_data < imm_rs2_data)};
      5'b00100: base_res_s = rs1_data ^ imm_rs2_data;
      5'b00110: base_res_s = rs1_data | imm_rs2_data;
      5'b00111: base_res_s = rs1_data & imm_rs2_data;
      5'b01111: base_res_s = imm_rs2_data;
      default:  base_res_s = {XLEN{1'b0}};
    endcase
  end

  // Operand signedness per M code, magnitudes and final result sign
  always_comb begin
    sa_s = 1'b0;
    sb_s = 1'b0;
    case (ALUCtrl[2:0])
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sa_s = rs1_data[XLEN-1];
        sb_s = imm_rs2_data[XLEN-1];
      end
      3'b010: begin
        sa_s = rs1_data[XLEN-1];
        sb_s = 1'b0;
      end
      default: begin
        sa_s = 1'b0;
        sb_s = 1'b0;
      end
    endcase
    // remainder follows the dividend; products and quotients follow sa ^ sb
    if (ALUCtrl[2:1] == 2'b11) neg_s = sa_s;
    else                       neg_s = sa_s ^ sb_s;
    if (sa_s) a_mag_s = -rs1_data;
    else      a_mag_s = rs1_data;
    if (sb_s) b_mag_s = -imm_rs2_data;
    else      b_mag_s = imm_rs2_data;
  end

  assign mul_sum_s   = {1'b0, hi_r} + {1'b0, (lo_r[0] ? b_mag_r : {XLEN{1'b0}})};
  assign div_shift_s = {hi_r, lo_r[XLEN-1]};
  assign div_diff_s  = div_shift_s - {1'b0, b_mag_r};

  // Sign correction and result selection applied in FIX
  always_comb begin
    prod_s = {hi_r, lo_r};
    quot_s = lo_r;
    rem_s  = hi_r;
    if (neg_r) begin
      prod_s = -{hi_r, lo_r};
      quot_s = -lo_r;
      rem_s  = -hi_r;
    end else begin
      prod_s = {hi_r, lo_r};
      quot_s = lo_r;
      rem_s  = hi_r;
    end
    case (mop_r)
      3'b000:                 fix_res_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res_s = b_zero_r ? {XLEN{1'b1}} : quot_s;
      3'b110, 3'b111:         fix_res_s = rem_s;
      default:                fix_res_s = {XLEN{1'b0}};
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // FSM next-state
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_s = start_m_s ? ST_RUN : ST_IDLE;
        ST_RUN:  state_s = (cnt_r == LAST_IT) ? ST_FIX : ST_RUN;
        ST_FIX:  state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Iteration counter, live only in RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               cnt_r <= {SH_W{1'b0}};
    else if (flush || (state_r != ST_RUN))  cnt_r <= {SH_W{1'b0}};
    else                                    cnt_r <= cnt_r + SH_W'(1);
  end

  // Shift-add / restoring-divide datapath; lo_r holds multiplier or dividend/quotient
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      b_mag_r  <= {XLEN{1'b0}};
      mop_r    <= 3'd0;
      neg_r    <= 1'b0;
      b_zero_r <= 1'b0;
      tag_r    <= {TAG_W{1'b0}};
    end else if (start_m_s) begin
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= a_mag_s;
      b_mag_r  <= b_mag_s;
      mop_r    <= ALUCtrl[2:0];
      neg_r    <= neg_s;
      b_zero_r <= (imm_rs2_data == {XLEN{1'b0}});
      tag_r    <= in_tag;
    end else if (state_r == ST_RUN) begin
      if (!mop_r[2]) begin
        hi_r <= mul_sum_s[XLEN:1];
        lo_r <= {mul_sum_s[0], lo_r[XLEN-1:1]};
      end else if (!div_diff_s[XLEN]) begin
        hi_r <= div_diff_s[XLEN-1:0];
        lo_r <= {lo_r[XLEN-2:0], 1'b1};
      end else begin
        hi_r <= div_shift_s[XLEN-1:0];
        lo_r <= {lo_r[XLEN-2:0], 1'b0};
      end
    end
  end

  // Result register: flush, then FIX load, then base-op load, then consumption
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      alu_data_r  <= {XLEN{1'b0}};
      out_tag_r   <= {TAG_W{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (state_r == ST_FIX) begin
      out_valid_r <= 1'b1;
      alu_data_r  <= fix_res_s;
      out_tag_r   <= tag_r;
    end else if (accept_s && !start_m_s) begin
      out_valid_r <= 1'b1;
      alu_data_r  <= base_res_s;
      out_tag_r   <= in_tag;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign alu_data  = alu_data_r;
  assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized + directed bench for seq_alu against a transaction-level model
// (result arithmetic plus expected completion cycle per accepted op).
module tb_seq_alu;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]  alu_ctrl, in_tag, out_tag;
  logic [31:0] rs1, rs2, alu_data;

  logic        e_in_valid, e_in_ready, e_out_valid, e_busy;
  logic [4:0]  e_op, e_tag, e_out_tag;
  logic [31:0] e_a, e_b, e_alu_data;

  seq_alu #(.XLEN(XLEN), .TAG_W(5), .EN_M(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUCtrl(alu_ctrl), .rs1_data(rs1), .imm_rs2_data(rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .alu_data(alu_data),
    .out_tag(out_tag), .busy(busy));

  seq_alu #(.XLEN(XLEN), .TAG_W(5), .EN_M(0)) dut0 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .ALUCtrl(e_op), .rs1_data(e_a), .imm_rs2_data(e_b), .in_tag(e_tag),
    .out_valid(e_out_valid), .out_ready(1'b1), .alu_data(e_alu_data),
    .out_tag(e_out_tag), .busy(e_busy));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference result from the operation definitions using 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input bit en_m);
    longint sa, sb;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0;
    case (op)
      5'b00000: r = a + b;
      5'b01000: r = a - b;
      5'b00001: r = a << b[4:0];
      5'b00101: r = a >> b[4:0];
      5'b01101: r = $unsigned($signed(a) >>> b[4:0]);
      5'b00010: r = {31'd0, $signed(a) < $signed(b)};
      5'b00011: r = {31'd0, a < b};
      5'b00100: r = a ^ b;
      5'b00110: r = a | b;
      5'b00111: r = a & b;
      5'b01111: r = b;
      5'b10000: begin p = 64'(sa * sb); r = p[31:0]; end
      5'b10001: begin p = 64'(sa * sb); r = p[63:32]; end
      5'b10010: begin p = 64'(sa * longint'({32'd0, b})); r = p[63:32]; end
      5'b10011: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      // 64-bit division yields the overflow case (quotient = A, remainder 0) naturally
      5'b10100: r = (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      5'b10101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'b10110: r = (b == 32'd0) ? a : 32'(sa % sb);
      5'b10111: r = (b == 32'd0) ? a : a % b;
      default:  r = 32'd0;
    endcase
    if (op[4] && !en_m) r = 32'd0;
    return r;
  endfunction

  typedef struct { logic [31:0] data; logic [4:0] tag; int due; } exp_t;
  exp_t q[$];

  // Cycle compare: outputs vs the pending-result queue, then account for the coming edge
  always @(negedge clk) begin : mon
    bit ev, eb;
    exp_t e;
    if (!rst) begin
      q.delete();
    end else begin
      ev = (q.size() > 0) && (q[0].due <= cyc);
      eb = (q.size() > 0) && (q[0].due > cyc);
      chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("in_ready", {31'd0, in_ready}, {31'd0, !eb && (!ev || out_ready) && !flush});
      if (ev && out_valid) begin
        chk("alu_data", alu_data, q[0].data);
        chk("out_tag", {27'd0, out_tag}, {27'd0, q[0].tag});
      end
      chk("m0_busy", {31'd0, e_busy}, 32'd0);
      if (flush) q.delete();
      else begin
        if (ev && out_ready) void'(q.pop_front());
        if (in_valid && in_ready) begin
          e.data = ref_result(alu_ctrl, rs1, rs2, 1'b1);
          e.tag  = in_tag;
          e.due  = cyc + 1 + ((alu_ctrl[4:3] == 2'b10) ? XLEN + 1 : 0);
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, output int stalls);
    logic acc;
    alu_ctrl = op; rs1 = a; rs2 = b; in_tag = tag; in_valid = 1'b1;
    stalls = 0; acc = 1'b0;
    while (!acc && stalls < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk);
      if (!acc) stalls++;
    end
    #1 in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept expected accept (op %b)", op);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic e_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
    e_op = op; e_a = a; e_b = b; e_tag = tag; e_in_valid = 1'b1;
    @(negedge clk); chk("m0_in_ready", {31'd0, e_in_ready}, 32'd1);
    @(posedge clk); #1 e_in_valid = 1'b0;
    chk("m0_out_valid", {31'd0, e_out_valid}, 32'd1);
    chk("m0_data", e_alu_data, exp);
    chk("m0_tag", {27'd0, e_out_tag}, {27'd0, tag});
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  localparam logic [4:0] BASE_OPS [12] = '{5'b00000, 5'b01000, 5'b00001, 5'b00101,
      5'b01101, 5'b00010, 5'b00011, 5'b00100, 5'b00110, 5'b00111, 5'b01111, 5'b01001};
  localparam logic [4:0]  B_OP [4] = '{5'b00000, 5'b01000, 5'b01101, 5'b00011};
  localparam logic [31:0] B_A  [4] = '{32'd7, 32'd5, 32'h8000_0000, 32'd1};
  localparam logic [31:0] B_B  [4] = '{32'd5, 32'd7, 32'd4, 32'hFFFF_FFFF};
  localparam logic [31:0] B_X  [4] = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000, 32'd1};
  localparam logic [4:0]  M_OP [9] = '{5'b10000, 5'b10001, 5'b10011, 5'b10100, 5'b10110,
      5'b10100, 5'b10110, 5'b10100, 5'b10110};
  localparam logic [31:0] M_A  [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7,
      32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
  localparam logic [31:0] M_B  [9] = '{32'd3, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0,
      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2};
  localparam logic [31:0] M_X  [9] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
      32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF};

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, n, r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = 5'd0; rs1 = 32'd0; rs2 = 32'd0; in_tag = 5'd0;
    e_in_valid = 1'b0; e_op = 5'd0; e_a = 32'd0; e_b = 32'd0; e_tag = 5'd0;
    #2 rst = 1'b0;
    #10;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_data", alu_data, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    chk("model_mulhsu", ref_result(5'b10010, 32'hFFFF_FFFF, 32'd2, 1'b1), 32'hFFFF_FFFF);
    chk("model_divu", ref_result(5'b10101, 32'd100, 32'd7, 1'b1), 32'd14);
    chk("model_remu", ref_result(5'b10111, 32'd100, 32'd7, 1'b1), 32'd2);

    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      send(B_OP[i], B_A[i], B_B[i], 5'(i + 1), st);
      chk("b2b_stall", st, 32'd0);
      chk("b2b_data", alu_data, B_X[i]);
      chk("b2b_tag", {27'd0, out_tag}, 32'(i + 1));
    end

    for (int i = 0; i < 9; i++) begin
      send(M_OP[i], M_A[i], M_B[i], 5'(i + 10), st);
      wait_valid(n);
      chk("m_latency", n, 32'(XLEN + 1));
      chk("m_data", alu_data, M_X[i]);
      chk("m_tag", {27'd0, out_tag}, 32'(i + 10));
    end

    @(posedge clk); #1 out_ready = 1'b0;
    send(5'b00000, 32'd2, 32'd3, 5'd9, st);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_data", alu_data, 32'd5);
      chk("bp_tag", {27'd0, out_tag}, 32'd9);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    send(5'b00100, 32'hF0, 32'hFF, 5'd10, st);
    chk("bp_release_stall", st, 32'd0);
    chk("bp_release_data", alu_data, 32'h0F);
    chk("bp_release_tag", {27'd0, out_tag}, 32'd10);

    send(5'b10101, 32'd100, 32'd7, 5'd3, st);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    send(5'b00000, 32'd1, 32'd1, 5'd21, st);
    chk("flush_add", alu_data, 32'd2);
    chk("flush_tag", {27'd0, out_tag}, 32'd21);

    send(5'b10101, 32'd100, 32'd7, 5'd4, st);
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rstm_busy", {31'd0, busy}, 32'd0);
    chk("rstm_valid", {31'd0, out_valid}, 32'd0);
    chk("rstm_data", alu_data, 32'd0);
    chk("rstm_tag", {27'd0, out_tag}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      r = $urandom_range(0, 19);
      if (r < 3)       alu_ctrl = {2'b10, 3'($urandom_range(0, 7))};
      else if (r == 3) alu_ctrl = 5'($urandom);
      else             alu_ctrl = BASE_OPS[$urandom_range(0, 11)];
      rs1 = rnd_val(); rs2 = rnd_val(); in_tag = 5'($urandom);
    end
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);

    #1;
    e_run(5'b10000, 32'd3, 32'd4, 5'd7, 32'd0);
    e_run(5'b00000, 32'd5, 32'd6, 5'd8, 32'd11);
    e_run(5'b01001, 32'd5, 32'd6, 5'd9, 32'd0);
    e_run(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'd0);
    repeat (2) @(posedge clk);

    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
